// File: rtl/pipe_types_pkg.sv
// Shared types for the pipeline sequencer: sequencer states and register constants.
package pipe_types_pkg;

  // RUN: normal operation; DDONE: data access finished, waiting on fetch;
  // HALTED: absorbing stop state after HALT retires.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DDONE  = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

  // Register $zero never creates a true dependence.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use detection and redirect-over-load-use priority resolution.
// Purely combinational; the caller gates the results with the advance condition.
module hazard_detect
  import pipe_types_pkg::*;
(
  input  logic       ex_memREN_i,
  input  logic [4:0] ex_dest_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       ex_redirect_i,
  output logic       load_use_o,     // raw load-use match
  output logic       hold_front_o,   // hold PC and IF/ID (load-use not overridden)
  output logic       flush_ifid_o,   // bubble into IF/ID
  output logic       flush_idex_o    // bubble into ID/EX
);

  logic dest_match;

  // A redirect discards the ID instruction anyway, so it overrides the load-use hold.
  always_comb begin
    dest_match   = (ex_dest_i == id_rs_i) || (ex_dest_i == id_rt_i);
    load_use_o   = ex_memREN_i && (ex_dest_i != REG_ZERO) && dest_match;
    hold_front_o = load_use_o && !ex_redirect_i;
    flush_ifid_o = ex_redirect_i;
    flush_idex_o = ex_redirect_i || load_use_o;
  end

endmodule

// File: rtl/pipeline_control.sv
// Central stall/flush sequencer: advance decision, stage enables/bubbles,
// data-latency masking, halt handling and stall/flush performance counters.
module pipeline_control
  import pipe_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             ex_memREN,
  input  logic [4:0]       ex_dest,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_redirect,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             dmem_mask,
  output logic             dload_cap,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  pc_state_t        state_q, state_d;
  logic             dmem_mask_q, dmem_mask_d;
  logic             halt_q, halt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic dreq;
  logic adv;
  logic load_use;
  logic hold_front;
  logic flush_ifid;
  logic flush_idex;
  logic stall_inc;
  logic flush_inc;

  hazard_detect u_hazard_detect (
    .ex_memREN_i   (ex_memREN),
    .ex_dest_i     (ex_dest),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .ex_redirect_i (ex_redirect),
    .load_use_o    (load_use),
    .hold_front_o  (hold_front),
    .flush_ifid_o  (flush_ifid),
    .flush_idex_o  (flush_idex)
  );

  // Advance decision and next state; a completed data access with no fetch parks in DDONE
  // so the access is not re-issued while the fetch finishes.
  always_comb begin
    state_d   = state_q;
    dreq      = (mem_dREN || mem_dWEN) && !dmem_mask_q;
    adv       = 1'b0;
    dload_cap = 1'b0;
    unique case (state_q)
      RUN: begin
        adv = ihit && (!dreq || dhit);
        if (wb_halt && adv) begin
          state_d = HALTED;
        end else if (dreq && dhit && !ihit) begin
          state_d   = DDONE;
          dload_cap = 1'b1;
        end
      end
      DDONE: begin
        adv = ihit;
        if (wb_halt) begin
          state_d = HALTED;
        end else if (ihit) begin
          state_d = RUN;
        end
      end
      HALTED: begin
        adv = 1'b0;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    dmem_mask_d = (state_d == DDONE);
    halt_d      = (state_d == HALTED);
  end

  // Stage enables and bubbles; everything freezes when the pipeline does not advance.
  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (adv) begin
      pc_en      = !hold_front;
      ifid_en    = !hold_front;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      ifid_flush = flush_ifid;
      idex_flush = flush_idex;
    end
  end

  // EX/MEM never needs a bubble from this sequencer.
  assign exmem_flush = 1'b0;

  // Saturating counters; HALTED contributes nothing since adv is 0 and the freeze term is excluded.
  always_comb begin
    stall_inc   = ((state_q != HALTED) && !adv) || (adv && load_use && !ex_redirect);
    flush_inc   = adv && ex_redirect;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if (flush_inc && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  // State, mask, halt and counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      dmem_mask_q <= 1'b0;
      halt_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      dmem_mask_q <= dmem_mask_d;
      halt_q      <= halt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign dmem_mask = dmem_mask_q;
  assign halt      = halt_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Self-checking bench for pipeline_control: directed scenarios plus randomized
// stimulus, checked against a flag-based behavioural model of the sequencer rules.
module tb_pipeline_control;

  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             ihit, dhit, mem_dREN, mem_dWEN, ex_memREN, ex_redirect, wb_halt;
  logic [4:0]       ex_dest, id_rs, id_rt;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, exmem_flush;
  logic             dmem_mask, dload_cap, halt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_control #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .ex_memREN(ex_memREN),
    .ex_dest(ex_dest), .id_rs(id_rs), .id_rt(id_rt),
    .ex_redirect(ex_redirect), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .dmem_mask(dmem_mask), .dload_cap(dload_cap),
    .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Model: "a data access already completed, waiting for fetch" and "halted".
  bit m_waiting_fetch;
  bit m_halted;
  int m_stalls;
  int m_flushes;
  bit last_adv;
  int cap_seen;
  int mask_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_waiting_fetch = 1'b0;
    m_halted        = 1'b0;
    m_stalls        = 0;
    m_flushes       = 0;
  endtask

  task automatic set_idle();
    ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
    ex_memREN = 1'b0; ex_redirect = 1'b0; wb_halt = 1'b0;
    ex_dest = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
  endtask

  // One clock: check outputs mid-cycle against the model, then let the model take the edge.
  // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
  task automatic step();
    bit lu, wants_data, adv, cap, exp_front;
    logic [10:0] exp_ctl, obs_ctl;
    @(negedge CLK);
    lu         = ex_memREN && (ex_dest != 5'd0) && (ex_dest == id_rs || ex_dest == id_rt);
    wants_data = (mem_dREN || mem_dWEN) && !m_waiting_fetch;
    if (m_halted)             adv = 1'b0;
    else if (m_waiting_fetch) adv = ihit;
    else                      adv = ihit && (!wants_data || dhit);
    cap       = !m_halted && !m_waiting_fetch && wants_data && dhit && !ihit;
    exp_front = adv && (ex_redirect || !lu);
    exp_ctl = {exp_front, exp_front, adv, adv, adv,
               adv && ex_redirect, adv && (ex_redirect || lu), 1'b0,
               m_waiting_fetch, cap, m_halted};
    obs_ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, dmem_mask, dload_cap, halt};
    chk("ctl", {21'd0, obs_ctl}, {21'd0, exp_ctl});
    chk("stall_cnt", {24'd0, stall_cnt}, m_stalls);
    chk("flush_cnt", {24'd0, flush_cnt}, m_flushes);
    $display("cyc=%0d ihit=%b dhit=%b dREN=%b dWEN=%b lu=%b redir=%b whalt=%b -> ctl=%b stall=%0d flush=%0d",
             cyc, ihit, dhit, mem_dREN, mem_dWEN, lu, ex_redirect, wb_halt, obs_ctl, stall_cnt, flush_cnt);
    if (dload_cap) cap_seen++;
    if (dmem_mask) mask_seen++;
    last_adv = adv;
    @(posedge CLK);
    if (!m_halted) begin
      if (!adv || (lu && !ex_redirect)) m_stalls = (m_stalls < CMAX) ? m_stalls + 1 : CMAX;
      if (adv && ex_redirect)           m_flushes = (m_flushes < CMAX) ? m_flushes + 1 : CMAX;
      if (wb_halt && (adv || m_waiting_fetch)) begin
        m_halted        = 1'b1;
        m_waiting_fetch = 1'b0;
      end else if (cap) begin
        m_waiting_fetch = 1'b1;
      end else if (m_waiting_fetch && ihit) begin
        m_waiting_fetch = 1'b0;
      end
    end
    cyc++;
    #1;
  endtask

  // Asynchronous reset pulse starting at posedge+1; ends aligned at the next posedge+1.
  task automatic reset_pulse();
    nRST = 1'b0;
    #2;
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_mask", {31'd0, dmem_mask}, 32'd0);
    chk("rst_stall", {24'd0, stall_cnt}, 32'd0);
    chk("rst_flush", {24'd0, flush_cnt}, 32'd0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    model_reset();
  endtask

  task automatic rand_inputs(input bit allow_halt);
    ihit        = ($urandom_range(3) != 0);
    dhit        = $urandom_range(1);
    mem_dREN    = ($urandom_range(9) < 3);
    mem_dWEN    = !mem_dREN && ($urandom_range(9) < 1);
    ex_memREN   = ($urandom_range(9) < 3);
    ex_redirect = ($urandom_range(9) < 2);
    ex_dest     = 5'($urandom_range(3));
    id_rs       = 5'($urandom_range(3));
    id_rt       = 5'($urandom_range(3));
    wb_halt     = allow_halt && ($urandom_range(49) == 0);
  endtask

  initial begin
    nRST = 1'b0;
    set_idle();
    model_reset();
    @(posedge CLK);
    #1;
    reset_pulse();

    // Free-running fetch with no hazards.
    for (int i = 0; i < 10; i++) step();
    chk("idle_stall", {24'd0, stall_cnt}, 32'd0);
    chk("idle_flush", {24'd0, flush_cnt}, 32'd0);

    // Load-use on rs: one held cycle.
    ex_memREN = 1'b1; ex_dest = 5'd5; id_rs = 5'd5;
    step();
    set_idle();
    step();
    chk("lu_stall", {24'd0, stall_cnt}, 32'd1);

    // Data read waiting three cycles, then completes together with fetch.
    mem_dREN = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) step();
    dhit = 1'b1;
    step();
    chk("dwait_adv", {31'd0, last_adv}, 32'd1);
    set_idle();
    step();
    chk("dwait_stall", {24'd0, stall_cnt}, 32'd4);

    // Data done before fetch: capture once, mask two cycles, then advance.
    cap_seen = 0; mask_seen = 0;
    mem_dREN = 1'b1; dhit = 1'b1; ihit = 1'b0;
    step();
    step();
    ihit = 1'b1;
    step();
    chk("ddone_adv", {31'd0, last_adv}, 32'd1);
    set_idle();
    step();
    chk("cap_pulses", cap_seen, 32'd1);
    chk("mask_cycles", mask_seen, 32'd2);
    chk("ddone_stall", {24'd0, stall_cnt}, 32'd6);

    // Redirect together with a load-use match.
    ex_redirect = 1'b1; ex_memREN = 1'b1; ex_dest = 5'd7; id_rt = 5'd7;
    step();
    set_idle();
    step();
    chk("redir_flush", {24'd0, flush_cnt}, 32'd1);
    chk("redir_stall", {24'd0, stall_cnt}, 32'd6);

    // Reset while in DDONE.
    mem_dWEN = 1'b1; dhit = 1'b1; ihit = 1'b0;
    step();
    chk("enter_ddone", {31'd0, dmem_mask}, 32'd1);
    reset_pulse();
    set_idle();
    step();

    // Counter saturation.
    ihit = 1'b0;
    for (int i = 0; i < CMAX + 10; i++) step();
    chk("stall_sat", {24'd0, stall_cnt}, CMAX);
    ihit = 1'b1; ex_redirect = 1'b1;
    for (int i = 0; i < CMAX + 10; i++) step();
    chk("flush_sat", {24'd0, flush_cnt}, CMAX);
    set_idle();

    // Random traffic without halt, then with occasional halt and resets.
    reset_pulse();
    for (int i = 0; i < 500; i++) begin
      rand_inputs(1'b0);
      step();
    end
    for (int r = 0; r < 4; r++) begin
      reset_pulse();
      for (int i = 0; i < 150; i++) begin
        rand_inputs(1'b1);
        step();
      end
    end

    // Halt accepted on an advancing cycle.
    set_idle();
    reset_pulse();
    step();
    wb_halt = 1'b1;
    step();
    chk("halt_rise", {31'd0, halt}, 32'd1);
    set_idle();
    for (int i = 0; i < 5; i++) step();
    chk("halt_frozen_pc", {31'd0, pc_en}, 32'd0);

    // Halt while waiting on fetch in DDONE.
    reset_pulse();
    mem_dREN = 1'b1; dhit = 1'b1; ihit = 1'b0;
    step();
    wb_halt = 1'b1;
    step();
    chk("halt_from_ddone", {31'd0, halt}, 32'd1);
    set_idle();
    for (int i = 0; i < 3; i++) step();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
